// File: rtl/l2_burst_pkg.sv
// Shared types and constants for the L2 <-> memory burst adapter.
// Also used by the bench so both sides agree on line/beat geometry.
package l2_burst_pkg;

   localparam int unsigned ADDR_W       = 32;
   localparam int unsigned L2_CACHELINE = 256;
   localparam int unsigned BURST_WIDTH  = 64;
   localparam int unsigned BEATS        = L2_CACHELINE / BURST_WIDTH;
   localparam int unsigned OFFSET_BITS  = $clog2(L2_CACHELINE / 8);
   localparam int unsigned BEAT_CNT_W   = $clog2(BEATS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_e;

   typedef logic [L2_CACHELINE-1:0] line_t;
   typedef logic [BURST_WIDTH-1:0]  beat_t;
   typedef logic [BEAT_CNT_W-1:0]   cnt_t;
   typedef logic [ADDR_W-1:0]       addr_t;

   // Extract beat idx from a line; constant-index loop keeps slicing static.
   function automatic beat_t line_beat(input line_t line, input cnt_t idx);
      beat_t b;
      b = '0;
      for (int i = 0; i < int'(BEATS); i++) begin
         if (idx == cnt_t'(i)) begin
            b = line[i*BURST_WIDTH +: BURST_WIDTH];
         end
      end
      return b;
   endfunction

   // Return line with beat idx replaced by beat.
   function automatic line_t line_insert(input line_t line, input cnt_t idx, input beat_t beat);
      line_t l;
      l = line;
      for (int i = 0; i < int'(BEATS); i++) begin
         if (idx == cnt_t'(i)) begin
            l[i*BURST_WIDTH +: BURST_WIDTH] = beat;
         end
      end
      return l;
   endfunction

endpackage

// File: rtl/l2_burst_adapter.sv
// Converts one 256-bit L2 line read/write into a 4-beat 64-bit memory burst,
// assembling fill beats into a line and serialising writeback lines.
module l2_burst_adapter
   import l2_burst_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [ADDR_W-1:0]       l2_pmem_address,
   input  logic                    l2_pmem_read,
   input  logic                    l2_pmem_write,
   input  logic [L2_CACHELINE-1:0] l2_pmem_wdata,
   output logic [L2_CACHELINE-1:0] l2_pmem_rdata,
   output logic                    l2_pmem_resp,
   output logic [ADDR_W-1:0]       mem_address,
   output logic                    mem_read,
   output logic                    mem_write,
   output logic [BURST_WIDTH-1:0]  mem_wdata,
   input  logic [BURST_WIDTH-1:0]  mem_rdata,
   input  logic                    mem_resp
);

   localparam cnt_t LAST_BEAT = cnt_t'(BEATS - 1);

   state_e state_q, state_d;
   cnt_t   cnt_q, cnt_d;
   addr_t  addr_q, addr_d;
   line_t  wline_q, wline_d;
   line_t  rdata_q, rdata_d;
   logic   mem_read_q, mem_read_d;
   logic   mem_write_q, mem_write_d;
   logic   resp_q, resp_d;
   beat_t  mem_wdata_q, mem_wdata_d;

   addr_t  aligned_addr;
   logic   unused_addr_bits;

   assign aligned_addr     = {l2_pmem_address[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
   assign unused_addr_bits = ^l2_pmem_address[OFFSET_BITS-1:0];

   // State and output registers; reset aborts any burst in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         wline_q     <= '0;
         rdata_q     <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         resp_q      <= 1'b0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         wline_q     <= wline_d;
         rdata_q     <= rdata_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         resp_q      <= resp_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   // Next-state logic; outputs are decoded from the next state so the
   // registered outputs line up with the state they belong to.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      wline_d     = wline_q;
      rdata_d     = rdata_q;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      resp_d      = 1'b0;
      mem_wdata_d = '0;

      unique case (state_q)
         IDLE: begin
            // Writeback wins over fill: the eviction must reach memory first.
            if (l2_pmem_write) begin
               addr_d  = aligned_addr;
               wline_d = l2_pmem_wdata;
               cnt_d   = '0;
               state_d = WRITE;
            end else if (l2_pmem_read) begin
               addr_d  = aligned_addr;
               cnt_d   = '0;
               state_d = READ;
            end
         end
         READ: begin
            if (mem_resp) begin
               rdata_d = line_insert(rdata_q, cnt_q, mem_rdata);
               cnt_d   = cnt_q + cnt_t'(1);
               if (cnt_q == LAST_BEAT) begin
                  state_d = DONE;
               end
            end
         end
         WRITE: begin
            if (mem_resp) begin
               cnt_d = cnt_q + cnt_t'(1);
               if (cnt_q == LAST_BEAT) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      mem_read_d  = (state_d == READ);
      mem_write_d = (state_d == WRITE);
      resp_d      = (state_d == DONE);
      if (state_d == WRITE) begin
         mem_wdata_d = line_beat(wline_d, cnt_d);
      end
   end

   assign l2_pmem_rdata = rdata_q;
   assign l2_pmem_resp  = resp_q;
   assign mem_address   = addr_q;
   assign mem_read      = mem_read_q;
   assign mem_write     = mem_write_q;
   assign mem_wdata     = mem_wdata_q;

endmodule
